sram_word_ctrl: RTL and testbench

Sequencer that serves 32-bit data-memory reads and writes from the MEM stage using the external 16-bit SRAM.
- Splits each word access into two half-word phases: low half first, then high half.
- Drives the SRAM pins for both phases.
- Raises `freeze` to stall the pipeline registers until the word completes.
- Sits between the MEM-stage control signals (`rd_en`, `wr_en`, `address`, store value) and the SRAM pins.

---
 rtl/sram_pkg.sv | 26 ++
 rtl/sram_dq_io.sv | 12 +
 rtl/sram_word_ctrl.sv | 142 ++++++++++++++
 tb/tb_sram_word_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and defaults for the 32-bit-over-16-bit SRAM word sequencer.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int unsigned DEF_WAIT_CYCLES = 1;
    localparam int unsigned DEF_BASE_ADDR   = 1024;
    localparam int unsigned PHASE_CNT_W     = 4;
    localparam int unsigned SRAM_DQ_W       = 16;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
        logic ub_n;
        logic lb_n;
    } sram_ctrl_t;

    localparam sram_ctrl_t CTRL_OFF = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1};

endpackage

// File: rtl/sram_dq_io.sv
// Tristate driver for the bidirectional SRAM data bus.
module sram_dq_io (
    inout  wire  [15:0] dq,
    input  logic        drive,
    input  logic [15:0] dout,
    output logic [15:0] din
);

    assign dq  = drive ? dout : 16'hzzzz;
    assign din = dq;

endmodule

// File: rtl/sram_word_ctrl.sv
// Serves 32-bit MEM-stage loads/stores as two 16-bit SRAM phases (low half, then high half),
// stalling the pipeline via freeze until the word completes.
module sram_word_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic              wr_en,
    input  logic [31:0]       address,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              freeze,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N
);

    localparam logic [PHASE_CNT_W-1:0] CNT_LAST = PHASE_CNT_W'(WAIT_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [PHASE_CNT_W-1:0]   cnt_q, cnt_d;
    logic                     op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]        lo_addr_q, lo_addr_d;
    logic [31:0]              wdata_q, wdata_d;
    logic [SRAM_DQ_W-1:0]     buf_lo_q;
    sram_ctrl_t               ctrl_q, ctrl_d;
    logic [ADDR_W-1:0]        addr_d;
    logic                     dq_oe, oe_d;
    logic [SRAM_DQ_W-1:0]     dq_out_q, dout_d;
    logic [SRAM_DQ_W-1:0]     dq_in;
    logic [ADDR_W-1:0]        off;
    logic                     phase_last;
    logic                     cap_lo, cap_hi;

    sram_dq_io u_dq_io (
        .dq    (SRAM_DQ),
        .drive (dq_oe),
        .dout  (dq_out_q),
        .din   (dq_in)
    );

    assign SRAM_CE_N = ctrl_q.ce_n;
    assign SRAM_OE_N = ctrl_q.oe_n;
    assign SRAM_WE_N = ctrl_q.we_n;
    assign SRAM_UB_N = ctrl_q.ub_n;
    assign SRAM_LB_N = ctrl_q.lb_n;

    // Next state, latched request, and pin values for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        lo_addr_d = lo_addr_q;
        wdata_d   = wdata_q;
        freeze    = 1'b0;
        ctrl_d    = CTRL_OFF;
        addr_d    = SRAM_ADDR;
        oe_d      = 1'b0;
        dout_d    = dq_out_q;
        off        = ADDR_W'(address - 32'(BASE_ADDR));
        phase_last = (cnt_q == CNT_LAST);
        cap_lo     = (state_q == LO) && phase_last && !op_wr_q;
        cap_hi     = (state_q == HI) && phase_last && !op_wr_q;

        case (state_q)
            IDLE: begin
                freeze = rd_en | wr_en;
                if (rd_en | wr_en) begin
                    state_d   = LO;
                    cnt_d     = '0;
                    op_wr_d   = wr_en;
                    lo_addr_d = (off >> 2) << 1;
                    wdata_d   = wdata;
                end
            end
            LO: begin
                freeze = 1'b1;
                if (phase_last) begin
                    state_d = HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PHASE_CNT_W'(1);
                end
            end
            HI: begin
                freeze = 1'b1;
                if (phase_last) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + PHASE_CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Pins are registered from the upcoming state so they line up with it.
        if (state_d == LO || state_d == HI) begin
            ctrl_d = '{ce_n: 1'b0, oe_n: op_wr_d, we_n: !op_wr_d, ub_n: 1'b0, lb_n: 1'b0};
            addr_d = (state_d == HI) ? lo_addr_d + ADDR_W'(1) : lo_addr_d;
            oe_d   = op_wr_d;
            dout_d = (state_d == HI) ? wdata_d[31:16] : wdata_d[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            lo_addr_q <= '0;
            wdata_q   <= '0;
            buf_lo_q  <= '0;
            rdata     <= '0;
            ctrl_q    <= CTRL_OFF;
            SRAM_ADDR <= '0;
            dq_oe     <= 1'b0;
            dq_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            lo_addr_q <= lo_addr_d;
            wdata_q   <= wdata_d;
            ctrl_q    <= ctrl_d;
            SRAM_ADDR <= addr_d;
            dq_oe     <= oe_d;
            dq_out_q  <= dout_d;
            if (cap_lo) buf_lo_q <= dq_in;
            if (cap_hi) rdata <= {dq_in, buf_lo_q};
        end
    end

endmodule

// File: tb/tb_sram_word_ctrl.sv
// Scoreboard bench for sram_word_ctrl with behavioural SRAMs on a 1-wait and a 3-wait instance.
module tb_sram_word_ctrl;
    import sram_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_mem;

    logic        rd_en, wr_en;
    logic [31:0] address, wdata, rdata;
    logic        freeze;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        ub_n, lb_n, we_n, ce_n, oe_n;

    logic        w3_rd_en, w3_wr_en;
    logic [31:0] w3_address, w3_wdata, w3_rdata;
    logic        w3_freeze;
    wire  [15:0] w3_sram_dq;
    logic [17:0] w3_sram_addr;
    logic        w3_ub_n, w3_lb_n, w3_we_n, w3_ce_n, w3_oe_n;

    logic [15:0] mem1 [0:63];
    logic [15:0] mem3 [0:63];
    logic [15:0] sh   [0:63];

    logic [31:0] sb [$];
    logic [31:0] exp_last;
    logic [31:0] exp_v;
    logic        prev_freeze;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    sram_word_ctrl #(.ADDR_W(18), .WAIT_CYCLES(1), .BASE_ADDR(1024)) u_dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address), .wdata(wdata),
        .rdata(rdata), .freeze(freeze), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_WE_N(we_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
    );

    sram_word_ctrl #(.ADDR_W(18), .WAIT_CYCLES(3), .BASE_ADDR(1024)) u_w3 (
        .clk(clk), .rst(rst), .rd_en(w3_rd_en), .wr_en(w3_wr_en), .address(w3_address),
        .wdata(w3_wdata), .rdata(w3_rdata), .freeze(w3_freeze), .SRAM_DQ(w3_sram_dq),
        .SRAM_ADDR(w3_sram_addr), .SRAM_UB_N(w3_ub_n), .SRAM_LB_N(w3_lb_n), .SRAM_WE_N(w3_we_n),
        .SRAM_CE_N(w3_ce_n), .SRAM_OE_N(w3_oe_n)
    );

    // Behavioural SRAMs: drive on read, store on write.
    assign sram_dq    = (!ce_n && !oe_n && we_n) ? mem1[sram_addr[5:0]] : 16'hzzzz;
    assign w3_sram_dq = (!w3_ce_n && !w3_oe_n && w3_we_n) ? mem3[w3_sram_addr[5:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= 16'hA000 + 16'(i);
                mem3[i] <= 16'h5000 + 16'(i);
            end
        end else begin
            if (!ce_n && !we_n) mem1[sram_addr[5:0]] <= sram_dq;
            if (!w3_ce_n && !w3_we_n) mem3[w3_sram_addr[5:0]] <= w3_sram_dq;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Completion monitor: a falling freeze outside reset marks DONE.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_freeze = 1'b0;
        end else begin
            if (prev_freeze && !freeze) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_v = sb.pop_front();
                    check("rdata", rdata, exp_v);
                end
            end
            prev_freeze = freeze;
        end
    end

    task automatic run_access(input bit wr, input bit rd, input logic [31:0] a,
                              input logic [31:0] d, input bit after_done, input bit release_req);
        logic [31:0] off;
        logic [17:0] lo;
        off = a - 32'd1024;
        lo  = 18'({off[17:2], 1'b0});
        if (wr) begin
            sh[lo[5:0]]      = d[15:0];
            sh[lo[5:0] + 1]  = d[31:16];
        end else begin
            exp_last = {sh[lo[5:0] + 1], sh[lo[5:0]]};
        end
        sb.push_back(exp_last);
        wr_en = wr; rd_en = rd; address = a; wdata = d;
        if (after_done) @(negedge clk);
        #1 check("freeze_req", 32'(freeze), 32'd1);
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            check("ph_freeze", 32'(freeze), 32'd1);
            check("ph_addr", 32'(sram_addr), 32'(lo) + 32'(ph));
            check("ph_ce_ub_lb", {29'd0, ce_n, ub_n, lb_n}, 32'd0);
            check("ph_we_n", 32'(we_n), 32'(!wr));
            check("ph_oe_n", 32'(oe_n), 32'(wr));
            check("ph_dq_oe", 32'(u_dut.dq_oe), 32'(wr));
            if (wr) check("ph_dq", 32'(sram_dq), (ph == 0) ? 32'(d[15:0]) : 32'(d[31:16]));
        end
        @(negedge clk);
        check("done_freeze", 32'(freeze), 32'd0);
        check("done_ce_n", 32'(ce_n), 32'd1);
        if (release_req) begin
            rd_en = 1'b0; wr_en = 1'b0;
            @(negedge clk);
            check("idle_freeze", 32'(freeze), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load_mem = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
        w3_rd_en = 1'b0; w3_wr_en = 1'b0; w3_address = '0; w3_wdata = '0;
        exp_last = '0; prev_freeze = 1'b0;
        for (int i = 0; i < 64; i++) sh[i] = 16'hA000 + 16'(i);
        @(negedge clk);
        load_mem = 1'b0;
        @(negedge clk);

        check("rst_ctrls", {27'd0, ce_n, we_n, oe_n, ub_n, lb_n}, 32'h1F);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_freeze", 32'(freeze), 32'd0);
        check("rst_dq_oe", 32'(u_dut.dq_oe), 32'd0);
        check("rst_state", 32'(u_dut.state_q), 32'(IDLE));
        rst = 1'b0;
        @(negedge clk);

        run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, 1'b1);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0,        1'b0, 1'b1);
        run_access(1'b1, 1'b1, 32'd1036, 32'h12345678, 1'b0, 1'b1);
        run_access(1'b0, 1'b1, 32'd1036, 32'h0,        1'b0, 1'b1);
        run_access(1'b0, 1'b1, 32'd1028, 32'h0,        1'b0, 1'b0);
        run_access(1'b0, 1'b1, 32'd1032, 32'h0,        1'b1, 1'b1);

        // Reset during HI of a load; request held through and after reset.
        exp_last = {sh[3], sh[2]};
        sb.push_back(exp_last);
        rd_en = 1'b1; address = 32'd1028;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_hi_addr", 32'(sram_addr), 32'd3);
        rst = 1'b1;
        #1;
        check("mid_rst_ce_n", 32'(ce_n), 32'd1);
        check("mid_rst_oe_n", 32'(oe_n), 32'd1);
        check("mid_rst_dq_oe", 32'(u_dut.dq_oe), 32'd0);
        check("mid_rst_rdata", rdata, 32'd0);
        check("mid_rst_state", 32'(u_dut.state_q), 32'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        #1 check("restart_freeze", 32'(freeze), 32'd1);
        @(negedge clk);
        check("restart_lo_addr", 32'(sram_addr), 32'd2);
        check("restart_lo_oe_n", 32'(oe_n), 32'd0);
        @(negedge clk);
        check("restart_hi_addr", 32'(sram_addr), 32'd3);
        @(negedge clk);
        check("restart_done_freeze", 32'(freeze), 32'd0);
        rd_en = 1'b0;
        @(negedge clk);

        // Three wait cycles per phase on the second instance.
        w3_rd_en = 1'b1; w3_address = 32'd1032;
        #1 check("w3_freeze_req", 32'(w3_freeze), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("w3_freeze", 32'(w3_freeze), 32'd1);
            check("w3_addr", 32'(w3_sram_addr), (c < 3) ? 32'd4 : 32'd5);
            check("w3_oe_n", 32'(w3_oe_n), 32'd0);
        end
        @(negedge clk);
        check("w3_done_freeze", 32'(w3_freeze), 32'd0);
        check("w3_rdata", w3_rdata, 32'h50055004);
        w3_rd_en = 1'b0;
        @(negedge clk);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
